// File: rtl/mult_operand_dispatcher.sv
// mult_operand_dispatcher
//   Buffers operand pairs in a small FIFO and feeds them one at a time to
//   multiplication_top over its start/ready handshake. Each product is captured
//   and held on a valid/ready output until the consumer takes it.
//   Optional feature macro: MULT_DISPATCH_TAG_EN (adds in_tag/out_tag, with
//   the tag stored alongside each FIFO entry).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | nothing in flight; waiting for a queued pair and an idle multiplier
//   START     | mul_start pulsed for this single cycle, operands on mul_a/mul_b
//   WAIT_BUSY | waiting for the multiplier to drop ready (start accepted)
//   WAIT_DONE | waiting for ready to return; product latched on that cycle
//   HOLD      | product presented on out_result until out_ready

module mult_operand_dispatcher #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int RW = 2 * WIDTH + 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef MULT_DISPATCH_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_start,
  input  logic             mul_ready,
  input  logic [RW-1:0]    mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RW-1:0]    out_result,
  output logic [CW-1:0]    fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             capture;
  logic             release_out;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign in_ready   = ~full;
  assign push       = in_valid & ~full;
  assign fifo_count = count;

  // FIFO storage; entries are not reset because count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and the per-cycle control strobes.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && mul_ready) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!mul_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mul_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_out = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered multiplier-side outputs; operands only change on a pop, so they
  // stay stable for the whole operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_start <= (state_next == START);
      if (pop) begin
        mul_a <= mem_a[rd_ptr];
        mul_b <= mem_b[rd_ptr];
      end
    end
  end

  // Registered consumer-side outputs: capture sets valid, handshake clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      if (capture) begin
        out_result <= mul_result;
        out_valid  <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_DISPATCH_TAG_EN
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [TAG_W-1:0] cur_tag;

  // Tag storage travels with the operand pair.
  always_ff @(posedge clk) begin
    if (push) mem_tag[wr_ptr] <= in_tag;
  end

  // Tag of the in-flight pair, moved to out_tag together with its product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_tag <= '0;
      out_tag <= '0;
    end else begin
      if (pop)     cur_tag <= mem_tag[rd_ptr];
      if (capture) out_tag <= cur_tag;
    end
  end
`endif

endmodule

// File: tb/tb_mult_operand_dispatcher.sv
module tb_mult_operand_dispatcher;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int RW    = 2 * WIDTH + 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_start;
  logic             mul_ready;
  logic [RW-1:0]    mul_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RW-1:0]    out_result;
  logic [CW-1:0]    fifo_count;
`ifdef MULT_DISPATCH_TAG_EN
  logic [TAG_W-1:0] out_tag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mult_operand_dispatcher #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef MULT_DISPATCH_TAG_EN
    .in_tag     (in_tag),
    .out_tag    (out_tag),
`endif
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_start  (mul_start),
    .mul_ready  (mul_ready),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [RW-1:0] x;
    logic [RW-1:0] y;
    x = RW'(a);
    y = RW'(b);
    return x * y;
  endfunction

  // Behavioural multiplication_top: start accepted while idle, ready low for a
  // random number of cycles, then the product appears with ready.
  int            lat_lo = 0;
  int            lat_hi = 4;
  logic          m_busy;
  int            m_cnt;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_ready  <= 1'b1;
      mul_result <= '0;
      m_busy     <= 1'b0;
      m_cnt      <= 0;
      m_a        <= '0;
      m_b        <= '0;
    end else if (!m_busy) begin
      if (mul_start && mul_ready) begin
        m_busy    <= 1'b1;
        mul_ready <= 1'b0;
        m_a       <= mul_a;
        m_b       <= mul_b;
        m_cnt     <= $urandom_range(lat_hi, lat_lo);
      end
    end else if (m_cnt == 0) begin
      mul_result <= product(m_a, m_b);
      mul_ready  <= 1'b1;
      m_busy     <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // Scoreboard: expected products queued on accepted pushes, compared on
  // every completed output handshake.
  typedef struct {
    logic [RW-1:0]    p;
    logic [TAG_W-1:0] t;
  } exp_t;

  exp_t exp_q[$];
  logic prev_start = 1'b0;
  int   n_out = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_start = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_t e;
        e.p = product(in_a, in_b);
        e.t = in_tag;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_result", out_result, e.p);
`ifdef MULT_DISPATCH_TAG_EN
          check("sb_tag", RW'(out_tag), RW'(e.t));
`endif
        end
      end
      if (mul_start) check("start_one_cycle", RW'(prev_start), RW'(0));
      if (m_busy) begin
        check("mul_a_stable", RW'(mul_a), RW'(m_a));
        check("mul_b_stable", RW'(mul_b), RW'(m_b));
      end
      prev_start = mul_start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
    int w;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    w = 0;
    while (!in_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) check("push_timeout", 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid(input string name);
    int w;
    w = 0;
    while (!out_valid && w < 200) begin
      tick();
      w++;
    end
    check(name, RW'(out_valid), RW'(1));
  endtask

  task automatic drain();
    int w;
    out_ready = 1'b1;
    w = 0;
    while ((exp_q.size() != 0 || out_valid || fifo_count != 0) && w < 1000) begin
      tick();
      w++;
    end
    check("drain_done", RW'(w < 1000), RW'(1));
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_out_valid"},  RW'(out_valid), RW'(0));
    check({name, "_out_result"}, out_result, RW'(0));
    check({name, "_mul_start"},  RW'(mul_start), RW'(0));
    check({name, "_mul_a"},      RW'(mul_a), RW'(0));
    check({name, "_mul_b"},      RW'(mul_b), RW'(0));
    check({name, "_fifo_count"}, RW'(fifo_count), RW'(0));
    check({name, "_in_ready"},   RW'(in_ready), RW'(1));
  endtask

  initial begin
    int seen;
    logic [RW-1:0] max_prod;

    // Power-on reset.
    #2;
    check_reset_state("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single pair, latency and one-cycle start pulse.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 64'd17;
    in_b      = 64'd27;
    tick();
    in_valid = 1'b0;
    check("start_not_early", RW'(mul_start), RW'(0));
    tick();
    check("start_latency", RW'(mul_start), RW'(1));
    tick();
    check("start_width", RW'(mul_start), RW'(0));
    wait_out_valid("valid_17x27");
    check("result_17x27", out_result, RW'(459));
    drain();

    // Back-pressure: one in HOLD, four filling the FIFO, sixth ignored.
    out_ready = 1'b0;
    push_pair(64'd3, 64'd4, 4'd0);
    wait_out_valid("valid_3x4");
    check("result_3x4", out_result, RW'(12));
    for (int i = 0; i < 4; i++)
      push_pair({$urandom, $urandom}, {$urandom, $urandom}, 4'(i));
    check("full_count", RW'(fifo_count), RW'(4));
    check("full_in_ready", RW'(in_ready), RW'(0));
    in_valid = 1'b1;
    in_a     = 64'd9;
    in_b     = 64'd9;
    repeat (3) tick();
    in_valid = 1'b0;
    check("full_count_after_6th", RW'(fifo_count), RW'(4));
    check("hold_result_3x4", out_result, RW'(12));
    drain();

    // Largest operands.
    max_prod = {1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001};
    out_ready = 1'b0;
    push_pair('1, '1, 4'd0);
    wait_out_valid("valid_max");
    check("result_max", out_result, max_prod);
    check("result_max_bit128", RW'(out_result[RW-1]), RW'(0));
    drain();

    // Reset while the multiplier is busy with two pairs queued.
    lat_lo = 20;
    lat_hi = 20;
    out_ready = 1'b1;
    push_pair(64'd7, 64'd8, 4'd0);
    push_pair(64'd11, 64'd12, 4'd0);
    push_pair(64'd13, 64'd14, 4'd0);
    seen = 0;
    while (mul_ready && seen < 50) begin
      tick();
      seen++;
    end
    tick();
    tick();
    check("busy_before_reset", RW'(mul_ready), RW'(0));
    check("queued_before_reset", RW'(fifo_count), RW'(2));
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_state("midrst");
    tick();
    reset = 1'b0;
    lat_lo = 0;
    lat_hi = 4;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("no_stale_valid", RW'(seen), RW'(0));
    check("count_after_reset", RW'(fifo_count), RW'(0));
    out_ready = 1'b0;
    push_pair(64'd5, 64'd6, 4'd0);
    wait_out_valid("valid_5x6");
    check("result_5x6", out_result, RW'(30));
    drain();

`ifdef MULT_DISPATCH_TAG_EN
    out_ready = 1'b0;
    push_pair(64'd2, 64'd3, 4'd3);
    push_pair(64'd4, 64'd5, 4'd5);
    wait_out_valid("valid_tag1");
    check("tag1_result", out_result, RW'(6));
    check("tag1_tag", RW'(out_tag), RW'(3));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_out_valid("valid_tag2");
    check("tag2_result", out_result, RW'(20));
    check("tag2_tag", RW'(out_tag), RW'(5));
    drain();
`endif

    // Randomized traffic with random back-pressure and multiplier latency.
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(99, 0) < 60);
      in_a      = {$urandom, $urandom};
      in_b      = {$urandom, $urandom};
      in_tag    = TAG_W'($urandom);
      out_ready = ($urandom_range(99, 0) < 50);
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("queue_empty_end", RW'(exp_q.size()), RW'(0));
    check("outputs_seen", RW'(n_out > 20), RW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
